// File: rtl/seg_kbd_monitor.sv
// seg_kbd_monitor: PS/2 scancode history plus multiplexed 7-segment driver; define SEG_LZB_EN for mode-1 leading-zero blanking
module seg_kbd_monitor #(
  parameter int DIGITS = 8,
  parameter int DEPTH = 4,
  parameter int SCAN_DIV = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  kbd_ready,
  input  logic [7:0]            kbd_data,
  output logic                  kbd_read,
  input  logic                  freeze,
  input  logic                  clear,
  input  logic                  mode,
  input  logic                  cpu_we,
  input  logic [4*DIGITS-1:0]   cpu_din,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            hist_count
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF = ACTIVE_LOW != 0 ? '1 : '0;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG_LZB_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif
  logic [7:0] hist [DEPTH];
  logic [4*DIGITS-1:0] value;
  logic [PW-1:0] pre;
  logic [DW-1:0] dig;
  logic [3:0] di, nib, top;
  logic [3:0] hnib [16];
  logic [3:0] vnib [8];
  logic blank, capture;
  assign capture = kbd_ready & kbd_read;
  assign di = 4'(dig);
  // read strobe is never high two cycles running, so each byte is consumed once
  always_ff @(posedge clk)
    kbd_read <= reset ? 1'b0 : kbd_ready & ~kbd_read & ~freeze;
  // newest byte enters at hist[0]; clear wins over a same-edge capture
  always_ff @(posedge clk)
    if (reset || clear) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
      hist_count <= '0;
    end else if (capture) begin
      hist[0] <= kbd_data;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
      hist_count <= hist_count == 4'(DEPTH) ? hist_count : hist_count + 4'd1;
    end
  // CPU-written hex value shown in mode 1
  always_ff @(posedge clk)
    if (reset) value <= '0;
    else if (cpu_we) value <= cpu_din;
  // prescaler steps the digit selector once per SCAN_DIV cycles
  always_ff @(posedge clk)
    if (reset) begin
      pre <= '0;
      dig <= '0;
    end else if (pre == PW'(SCAN_DIV - 1)) begin
      pre <= '0;
      dig <= dig == DW'(DIGITS - 1) ? '0 : dig + 1'b1;
    end else pre <= pre + 1'b1;
  // select the nibble and blanking for the current digit
  always_comb begin
    hnib = '{default: 4'h0};
    vnib = '{default: 4'h0};
    top = 4'h0;
    for (int k = 0; k < 2*DEPTH; k++) hnib[k] = hist[k/2][4*(k%2) +: 4];
    for (int k = 0; k < DIGITS; k++) begin
      vnib[k] = value[4*k +: 4];
      if (value[4*k +: 4] != 4'h0) top = 4'(k);
    end
    nib = mode ? vnib[di[2:0]] : hnib[di];
    blank = mode ? (LZB && di > top)
                 : ({1'b0, di} >= 5'(2*DEPTH) || {1'b0, di[3:1]} >= hist_count);
  end
  // registered outputs; XOR with the off pattern applies the polarity
  always_ff @(posedge clk)
    if (reset) begin
      an <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an <= AN_OFF ^ (DIGITS'(1) << dig);
      seg <= SEG_OFF ^ (blank ? 8'h00 : {1'b0, HEX[nib]});
    end
endmodule

// File: tb/tb_seg_kbd_monitor.sv
// tb_seg_kbd_monitor: directed stimulus against a queue-based behavioural model of seg_kbd_monitor
module tb_seg_kbd_monitor;
  localparam int DIGITS = 8, DEPTH = 4, SCAN_DIV = 3;
  logic clk = 0, reset = 1, kbd_ready = 0, kbd_read, freeze = 0, clear = 0, mode = 0, cpu_we = 0;
  logic [7:0] kbd_data = 0, seg;
  logic [31:0] cpu_din = 0;
  logic [7:0] an;
  logic [3:0] hist_count;
  int total = 0, passed = 0;
  seg_kbd_monitor #(.DIGITS(DIGITS), .DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .kbd_ready(kbd_ready), .kbd_data(kbd_data), .kbd_read(kbd_read),
    .freeze(freeze), .clear(clear), .mode(mode), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .seg(seg), .an(an), .hist_count(hist_count));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    else passed++;
  endtask
  // model: newest-first byte queue, CPU value, and cycles since reset
  logic [6:0] hexp [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0] q [$];
  logic [31:0] mval;
  int n, md;
  bit valid = 0;
  logic e_rd;
  logic [7:0] e_an, e_seg;
  function automatic logic [7:0] exp_seg(input int d);
    logic [3:0] nb;
    bit blank;
    if (mode) begin
      nb = 4'(mval >> (4*d));
      blank = 0;
`ifdef SEG_LZB_EN
      blank = d > 0 && (mval >> (4*d)) == 0;
`endif
    end else begin
      blank = d/2 >= q.size();
      nb = blank ? 4'h0 : (d % 2 == 1 ? q[d/2][7:4] : q[d/2][3:0]);
    end
    return blank ? 8'hFF : ~{1'b0, hexp[nb]};
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      mval = 0;
      n = 0;
      e_rd = 0;
      e_an = 8'hFF;
      e_seg = 8'hFF;
      valid = 1;
    end else if (valid) begin
      md = (n / SCAN_DIV) % DIGITS;
      e_an = ~(8'd1 << md);
      e_seg = exp_seg(md);
      if (clear) q.delete();
      else if (kbd_ready && e_rd) begin
        q.push_front(kbd_data);
        if (q.size() > DEPTH) void'(q.pop_back());
      end
      if (cpu_we) mval = cpu_din;
      e_rd = kbd_ready && !e_rd && !freeze;
      n++;
    end
  end
  always @(negedge clk)
    if (valid) begin
      chk("kbd_read", kbd_read, e_rd);
      chk("hist_count", hist_count, 32'(q.size()));
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
    end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [7:0] b);
    bit got = 0;
    kbd_ready = 1;
    kbd_data = b;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (kbd_read) begin
        @(posedge clk);
        #2;
        got = 1;
      end
    end
    chk("push_timeout", got, 1);
  endtask
  task automatic wait_rd();
    bit got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = kbd_read;
    end
    chk("read_timeout", got, 1);
  endtask
  task automatic wait_an(input logic [7:0] t);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = an == t;
    end
    chk("an_reach", got, 1);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_read", kbd_read, 0);
    chk("rst_count", hist_count, 0);
    tick();
    reset = 0;
    push(8'h1C);
    push(8'hF0);
    push(8'h1C);
    kbd_ready = 0;
    @(negedge clk);
    chk("hs_count", hist_count, 3);
    wait_an(8'hEF);
    chk("hs_dig4", seg, 8'hC6);
    wait_an(8'hDF);
    chk("hs_dig5", seg, 8'hF9);
    wait_an(8'hBF);
    chk("hs_dig6_blank", seg, 8'hFF);
    kbd_ready = 1;
    kbd_data = 8'h77;
    wait_rd();
    kbd_ready = 0;
    tick();
    @(negedge clk);
    chk("drop_count", hist_count, 3);
    clear = 1;
    tick();
    clear = 0;
    for (int i = 1; i <= 6; i++) push(8'(8'h11 * i));
    kbd_ready = 0;
    @(negedge clk);
    chk("ovf_count", hist_count, 4);
    wait_an(8'hFE);
    chk("ovf_dig0", seg, 8'h82);
    wait_an(8'h7F);
    chk("ovf_dig7", seg, 8'hB0);
    freeze = 1;
    kbd_ready = 1;
    kbd_data = 8'hAA;
    repeat (6) begin
      @(negedge clk);
      chk("frozen_read", kbd_read, 0);
    end
    freeze = 0;
    wait_rd();
    clear = 1;
    tick();
    clear = 0;
    kbd_ready = 0;
    @(negedge clk);
    chk("clr_count", hist_count, 0);
    push(8'h5A);
    kbd_ready = 0;
    wait_an(8'h7F);
    wait_an(8'hFE);
    chk("scan_dig0", seg, 8'h88);
    @(negedge clk);
    chk("hold1", an, 8'hFE);
    @(negedge clk);
    chk("hold2", an, 8'hFE);
    @(negedge clk);
    chk("step", an, 8'hFD);
    chk("scan_dig1", seg, 8'h92);
    wait_an(8'hFB);
    chk("scan_dig2", seg, 8'hFF);
    cpu_din = 32'h0000_00B3;
    cpu_we = 1;
    mode = 1;
    tick();
    cpu_we = 0;
    wait_an(8'hFE);
    chk("m1_dig0", seg, 8'hB0);
    wait_an(8'hFD);
    chk("m1_dig1", seg, 8'h83);
    wait_an(8'hFB);
`ifdef SEG_LZB_EN
    chk("m1_dig2", seg, 8'hFF);
`else
    chk("m1_dig2", seg, 8'hC0);
`endif
    kbd_ready = 1;
    kbd_data = 8'h42;
    wait_rd();
    reset = 1;
    @(negedge clk);
    chk("mid_rst_an", an, 8'hFF);
    chk("mid_rst_seg", seg, 8'hFF);
    chk("mid_rst_read", kbd_read, 0);
    chk("mid_rst_count", hist_count, 0);
    tick();
    reset = 0;
    kbd_ready = 0;
    repeat (4) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
